spi_slave: RTL and testbench

SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, that sits at the far end of the link from spi_master.
- Oversamples spi_sck, spi_cs_n and spi_mosi in the local clk domain.
- Deserialises MOSI into rx_data.
- Serialises a one-word holding buffer onto MISO.
- Supports back-to-back words while spi_cs_n stays low.

---
 rtl/spi_slave.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first.
// sck, cs_n and mosi are oversampled in the clk domain. MOSI is deserialised
// into rx_data, and a one-word holding buffer is serialised onto MISO.
// Back-to-back words are supported while cs_n stays low.
// Optional feature: define SPI_SLAVE_FRAME_ERR_EN to add the frame_err output,
// which flags truncated words and transmit underruns.
module spi_slave #(
  parameter int DATA_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   busy,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                   frame_err
`endif
);

  localparam int CNT_W = $clog2(DATA_LENGTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Bit 0 = sck, bit 1 = cs_n, bit 2 = mosi
  logic [2:0] pin_in;
  logic [2:0] pin_sync;
  logic [2:0] pin_hist;

  assign pin_in = {spi_mosi, spi_cs_n, spi_sck};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [2:0] chain_reg;  // [0] meta, [1] synced, [2] history

      // Two-FF synchroniser plus one history FF for edge detection
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[1:0], pin_in[gi]};
        end
      end

      assign pin_sync[gi] = chain_reg[1];
      assign pin_hist[gi] = chain_reg[2];
    end
  endgenerate

  logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_bit;

  assign sck_rise = pin_sync[0] & ~pin_hist[0];
  assign sck_fall = ~pin_sync[0] & pin_hist[0];
  assign cs_rise  = pin_sync[1] & ~pin_hist[1];
  assign cs_fall  = ~pin_sync[1] & pin_hist[1];
  assign mosi_bit = pin_sync[2];

  state_t                 state_reg, state_next;
  logic [DATA_LENGTH-1:0] hold_reg, hold_next;
  logic                   hold_full_reg, hold_full_next;
  logic [DATA_LENGTH-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_LENGTH-1:0] rx_shift_reg, rx_shift_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   reload_reg, reload_next;
  logic [DATA_LENGTH-1:0] rx_data_reg, rx_data_next;
  logic                   rx_valid_reg, rx_valid_next;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic                   frame_err_reg, frame_err_next;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      bit_cnt_reg   <= '0;
      reload_reg    <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      tx_shift_reg  <= tx_shift_next;
      rx_shift_reg  <= rx_shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      reload_reg    <= reload_next;
      rx_data_reg   <= rx_data_next;
      rx_valid_reg  <= rx_valid_next;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_reg <= frame_err_next;
`endif
    end
  end

  // Next-state logic: frame control, shifting, holding buffer
  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    tx_shift_next  = tx_shift_reg;
    rx_shift_next  = rx_shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    reload_next    = reload_reg;
    rx_data_next   = rx_data_reg;
    rx_valid_next  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_next = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          // An empty buffer is an underrun: the word goes out as zeros
          state_next     = ACTIVE;
          tx_shift_next  = hold_full_reg ? hold_reg : '0;
          hold_full_next = 1'b0;
          bit_cnt_next   = '0;
          reload_next    = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_next = ~hold_full_reg;
`endif
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // cs_n wins over any coincident sck edge; partial words are dropped
          state_next   = IDLE;
          bit_cnt_next = '0;
          reload_next  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_next = (bit_cnt_reg != '0);
`endif
        end else if (sck_rise) begin
          rx_shift_next = {rx_shift_reg[DATA_LENGTH-2:0], mosi_bit};
          if (bit_cnt_reg == CNT_W'(DATA_LENGTH - 1)) begin
            bit_cnt_next  = '0;
            reload_next   = 1'b1;
            rx_data_next  = {rx_shift_reg[DATA_LENGTH-2:0], mosi_bit};
            rx_valid_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else if (sck_fall) begin
          // The falling edge after a word's last bit presents the next word's MSB
          if (reload_reg) begin
            tx_shift_next  = hold_full_reg ? hold_reg : '0;
            hold_full_next = 1'b0;
            reload_next    = 1'b0;
          end else begin
            tx_shift_next = {tx_shift_reg[DATA_LENGTH-2:0], 1'b0};
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A write in the same cycle as a load refills the buffer after it is drained
    if (tx_valid && !hold_full_reg) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end
  end

  assign tx_ready = ~hold_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = (state_reg == ACTIVE);
  assign spi_miso = (state_reg == ACTIVE) & tx_shift_reg[DATA_LENGTH-1];
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave; the bench plays the SPI master.
module tb_spi_slave;

  localparam int HALF = 6;  // clk cycles per sck phase

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave #(.DATA_LENGTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Count rx_valid cycles and log received words
  int         rx_cnt = 0;
  logic [7:0] rx_log [0:31];
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_log[rx_cnt % 32] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
  end

  // Count frame_err cycles
  int ferr_cnt = 0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Clock n bits MSB first; MISO sampled at each sck rising edge
  task automatic sck_bits(input logic [7:0] out, input int n, output logic [7:0] in);
    in = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = out[7-i];
      wait_clk(HALF);
      spi_sck  = 1'b1;
      in[7-i]  = spi_miso;
      wait_clk(HALF);
      spi_sck  = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] m1, m2;
    int rx_base, ferr_base;

    rst      = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(3);
    check("reset_miso", spi_miso, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_ready", tx_ready, 1);
    rst = 1'b0;
    wait_clk(5);
    check("post_reset_busy", busy, 0);
    $display("reset: released");

    // 1: preloaded 0x66, master sends 0xAA
    rx_base = rx_cnt; ferr_base = ferr_cnt;
    tx_write(8'h66);
    check("t1_tx_ready_full", tx_ready, 0);
    cs_low();
    check("t1_busy_active", busy, 1);
    check("t1_tx_ready_loaded", tx_ready, 1);
    sck_bits(8'hAA, 8, m1);
    cs_high();
    check("t1_rx_count", rx_cnt - rx_base, 1);
    check("t1_rx_data", rx_log[rx_base % 32], 8'hAA);
    check("t1_master_rx", m1, 8'h66);
    check("t1_busy_idle", busy, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t1_frame_err", ferr_cnt - ferr_base, 0);
`endif
    $display("txn1: mosi=aa miso=%h rx=%h", m1, rx_log[rx_base % 32]);

    // 2: underrun, master sends 0x5A
    rx_base = rx_cnt; ferr_base = ferr_cnt;
    cs_low();
    sck_bits(8'h5A, 8, m1);
    cs_high();
    check("t2_rx_count", rx_cnt - rx_base, 1);
    check("t2_rx_data", rx_log[rx_base % 32], 8'h5A);
    check("t2_master_rx", m1, 8'h00);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t2_frame_err", ferr_cnt - ferr_base, 1);
`endif
    $display("txn2: mosi=5a miso=%h rx=%h", m1, rx_log[rx_base % 32]);

    // 3: two back-to-back words
    rx_base = rx_cnt; ferr_base = ferr_cnt;
    tx_write(8'h81);
    cs_low();
    tx_write(8'h7E);
    check("t3_tx_ready_refilled", tx_ready, 0);
    sck_bits(8'h3C, 8, m1);
    sck_bits(8'hC3, 8, m2);
    cs_high();
    check("t3_rx_count", rx_cnt - rx_base, 2);
    check("t3_rx_word0", rx_log[rx_base % 32], 8'h3C);
    check("t3_rx_word1", rx_log[(rx_base + 1) % 32], 8'hC3);
    check("t3_master_rx0", m1, 8'h81);
    check("t3_master_rx1", m2, 8'h7E);
    check("t3_tx_ready_end", tx_ready, 1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t3_frame_err", ferr_cnt - ferr_base, 0);
`endif
    $display("txn3: miso=%h,%h rx=%h,%h", m1, m2, rx_log[rx_base % 32], rx_log[(rx_base + 1) % 32]);

    // 4: write while full is dropped
    rx_base = rx_cnt;
    tx_write(8'h11);
    tx_write(8'h22);
    check("t4_tx_ready_full", tx_ready, 0);
    cs_low();
    check("t4_tx_ready_loaded", tx_ready, 1);
    sck_bits(8'h00, 8, m1);
    cs_high();
    check("t4_master_rx", m1, 8'h11);
    check("t4_rx_data", rx_log[rx_base % 32], 8'h00);
    $display("txn4: miso=%h", m1);

    // 5: truncated word after 3 bits
    rx_base = rx_cnt; ferr_base = ferr_cnt;
    tx_write(8'h99);
    cs_low();
    sck_bits(8'hFF, 3, m1);
    cs_high();
    check("t5_rx_count", rx_cnt - rx_base, 0);
    check("t5_miso", spi_miso, 0);
    check("t5_busy", busy, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t5_frame_err", ferr_cnt - ferr_base, 1);
`endif
    $display("txn5: truncated after 3 bits, rx_count=%0d", rx_cnt - rx_base);

    // 6: reset mid-frame, then a clean frame
    rx_base = rx_cnt;
    tx_write(8'h5C);
    cs_low();
    tx_write(8'h33);
    check("t6_tx_ready_full", tx_ready, 0);
    sck_bits(8'hF0, 4, m1);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    check("t6_rst_miso", spi_miso, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tx_ready", tx_ready, 1);
    check("t6_rst_rx_data", rx_data, 0);
    check("t6_rst_rx_valid", rx_valid, 0);
    sck_bits(8'h0F, 4, m1);
    wait_clk(4);
    check("t6_ignored_busy", busy, 0);
    check("t6_ignored_rx", rx_cnt - rx_base, 0);
    cs_high();
    cs_low();
    check("t6_busy_new_frame", busy, 1);
    sck_bits(8'hA5, 8, m1);
    cs_high();
    check("t6_rx_count", rx_cnt - rx_base, 1);
    check("t6_rx_data", rx_data, 8'hA5);
    check("t6_master_rx", m1, 8'h00);
    $display("txn6: after reset rx=%h miso=%h", rx_data, m1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
